// File: rtl/vending_machine.sv
// Four-product coin-operated vending controller: accumulates coin credit,
// dispenses on an affordable selection and returns change or a full refund.
module vending_machine (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] money,
    input  logic [2:0] drink_choose,
    input  logic       cancel,
    output logic [5:0] change,
    output logic [3:0] drink_out
);

    logic [5:0] balance_q, balance_d;
    logic [5:0] money_q;
    logic [2:0] choose_q;
    logic [5:0] change_q, change_d;
    logic [3:0] drink_q, drink_d;

    logic       coin_evt;
    logic       sel_evt;
    logic [5:0] coin;
    logic [6:0] avail;
    logic [6:0] remainder;
    logic [4:0] price;
    logic [3:0] prod_bit;
    logic       prod_known;

    always_comb begin
        coin_evt = (money != 6'd0) && (money != money_q);
        sel_evt  = (drink_choose != 3'd0) && (drink_choose != choose_q);
        coin     = coin_evt ? money : 6'd0;
        avail    = {1'b0, balance_q} + {1'b0, coin};

        price      = 5'd0;
        prod_bit   = 4'b0000;
        prod_known = 1'b0;
        case (drink_choose)
            3'b001: begin price = 5'd10; prod_bit = 4'b0001; prod_known = 1'b1; end
            3'b010: begin price = 5'd15; prod_bit = 4'b0010; prod_known = 1'b1; end
            3'b100: begin price = 5'd20; prod_bit = 4'b0100; prod_known = 1'b1; end
            3'b111: begin price = 5'd25; prod_bit = 4'b1000; prod_known = 1'b1; end
            default: ;
        endcase

        remainder = avail - {2'b00, price};

        balance_d = avail[5:0];
        change_d  = 6'd0;
        drink_d   = 4'b0000;

        // Overflowing coin is bounced straight back and masks any other request.
        if (avail > 7'd63) begin
            balance_d = balance_q;
            change_d  = coin;
        end else if (cancel) begin
            balance_d = 6'd0;
            change_d  = avail[5:0];
        end else if (sel_evt && prod_known) begin
            if (avail >= {2'b00, price}) begin
                drink_d   = prod_bit;
                change_d  = remainder[5:0];
                balance_d = 6'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            balance_q <= 6'd0;
            money_q   <= 6'd0;
            choose_q  <= 3'd0;
            change_q  <= 6'd0;
            drink_q   <= 4'b0000;
        end else begin
            balance_q <= balance_d;
            money_q   <= money;
            choose_q  <= drink_choose;
            change_q  <= change_d;
            drink_q   <= drink_d;
        end
    end

    assign change    = change_q;
    assign drink_out = drink_q;

endmodule

// File: tb/tb_vending_machine.sv
// Directed testbench for vending_machine with hand-computed expectations.
module tb_vending_machine;

    logic       clk;
    logic       rst_n;
    logic [5:0] money;
    logic [2:0] drink_choose;
    logic       cancel;
    logic [5:0] change;
    logic [3:0] drink_out;

    int vectors;
    int miscompares;

    vending_machine dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .money        (money),
        .drink_choose (drink_choose),
        .cancel       (cancel),
        .change       (change),
        .drink_out    (drink_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [5:0] m, input logic [2:0] d, input logic c);
        @(negedge clk);
        money        = m;
        drink_choose = d;
        cancel       = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [5:0] exp_change,
                               input logic [3:0] exp_drink, input logic [5:0] exp_balance);
        vectors++;
        assert (change === exp_change) else begin
            miscompares++;
            $display("[TB] FAIL %s change: observed %0d expected %0d", tag, change, exp_change);
            $error("[TB] %s change", tag);
        end
        vectors++;
        assert (drink_out === exp_drink) else begin
            miscompares++;
            $display("[TB] FAIL %s drink_out: observed %b expected %b", tag, drink_out, exp_drink);
            $error("[TB] %s drink_out", tag);
        end
        vectors++;
        assert (dut.balance_q === exp_balance) else begin
            miscompares++;
            $display("[TB] FAIL %s balance: observed %0d expected %0d", tag, dut.balance_q, exp_balance);
            $error("[TB] %s balance", tag);
        end
    endtask

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst_n        = 1'b0;
        money        = 6'd0;
        drink_choose = 3'd0;
        cancel       = 1'b0;
        #23;
        checkOutput("reset", 6'd0, 4'b0000, 6'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Held coin credits once; cancel refunds the total.
        applyStimulus(6'd1, 3'd0, 1'b0);  checkOutput("coin1",       6'd0, 4'b0000, 6'd1);
        applyStimulus(6'd5, 3'd0, 1'b0);  checkOutput("coin5",       6'd0, 4'b0000, 6'd6);
        applyStimulus(6'd5, 3'd0, 1'b0);  checkOutput("hold5a",      6'd0, 4'b0000, 6'd6);
        applyStimulus(6'd5, 3'd0, 1'b0);  checkOutput("hold5b",      6'd0, 4'b0000, 6'd6);
        applyStimulus(6'd0, 3'd0, 1'b1);  checkOutput("cancel6",     6'd6, 4'b0000, 6'd0);
        applyStimulus(6'd0, 3'd0, 1'b0);  checkOutput("cancel_end",  6'd0, 4'b0000, 6'd0);

        // Purchase with change.
        applyStimulus(6'd10, 3'd0, 1'b0);    checkOutput("coin10",   6'd0, 4'b0000, 6'd10);
        applyStimulus(6'd5, 3'd0, 1'b0);     checkOutput("coin5b",   6'd0, 4'b0000, 6'd15);
        applyStimulus(6'd0, 3'd0, 1'b0);     checkOutput("nocoin",   6'd0, 4'b0000, 6'd15);
        applyStimulus(6'd0, 3'b001, 1'b0);   checkOutput("buy001",   6'd5, 4'b0001, 6'd0);
        applyStimulus(6'd0, 3'd0, 1'b0);     checkOutput("pulse_end",6'd0, 4'b0000, 6'd0);

        // Unaffordable selections with zero balance.
        applyStimulus(6'd0, 3'b111, 1'b0);   checkOutput("poor111",  6'd0, 4'b0000, 6'd0);
        applyStimulus(6'd0, 3'b010, 1'b0);   checkOutput("poor010",  6'd0, 4'b0000, 6'd0);
        applyStimulus(6'd0, 3'd0, 1'b0);     checkOutput("idle1",    6'd0, 4'b0000, 6'd0);

        // Large change, then a second purchase.
        applyStimulus(6'd50, 3'd0, 1'b0);    checkOutput("coin50",   6'd0,  4'b0000, 6'd50);
        applyStimulus(6'd0, 3'b100, 1'b0);   checkOutput("buy100",   6'd30, 4'b0100, 6'd0);
        applyStimulus(6'd25, 3'd0, 1'b0);    checkOutput("coin25",   6'd0,  4'b0000, 6'd25);
        applyStimulus(6'd0, 3'b001, 1'b0);   checkOutput("buy001b",  6'd15, 4'b0001, 6'd0);
        applyStimulus(6'd0, 3'b010, 1'b0);   checkOutput("after010", 6'd0,  4'b0000, 6'd0);
        applyStimulus(6'd0, 3'd0, 1'b0);     checkOutput("idle2",    6'd0,  4'b0000, 6'd0);

        // Exact price, then held cancel on empty balance.
        applyStimulus(6'd10, 3'd0, 1'b0);    checkOutput("coin10b",  6'd0, 4'b0000, 6'd10);
        applyStimulus(6'd0, 3'b001, 1'b0);   checkOutput("exact001", 6'd0, 4'b0001, 6'd0);
        applyStimulus(6'd0, 3'd0, 1'b1);     checkOutput("cancel0a", 6'd0, 4'b0000, 6'd0);
        applyStimulus(6'd0, 3'd0, 1'b1);     checkOutput("cancel0b", 6'd0, 4'b0000, 6'd0);
        applyStimulus(6'd0, 3'd0, 1'b0);     checkOutput("idle3",    6'd0, 4'b0000, 6'd0);

        // Coin arriving with the selection counts toward it.
        applyStimulus(6'd10, 3'd0, 1'b0);    checkOutput("coin10c",  6'd0, 4'b0000, 6'd10);
        applyStimulus(6'd15, 3'b111, 1'b0);  checkOutput("coinsel",  6'd0, 4'b1000, 6'd0);
        applyStimulus(6'd0, 3'd0, 1'b0);     checkOutput("idle4",    6'd0, 4'b0000, 6'd0);

        // Overflow bounces the coin and masks cancel/select.
        applyStimulus(6'd50, 3'd0, 1'b0);    checkOutput("coin50b",  6'd0,  4'b0000, 6'd50);
        applyStimulus(6'd20, 3'd0, 1'b1);    checkOutput("ovf_can",  6'd20, 4'b0000, 6'd50);
        applyStimulus(6'd0, 3'd0, 1'b0);     checkOutput("ovf_end",  6'd0,  4'b0000, 6'd50);
        applyStimulus(6'd20, 3'b001, 1'b0);  checkOutput("ovf_sel",  6'd20, 4'b0000, 6'd50);
        applyStimulus(6'd0, 3'd0, 1'b0);     checkOutput("idle5",    6'd0,  4'b0000, 6'd50);
        applyStimulus(6'd13, 3'd0, 1'b0);    checkOutput("bal63",    6'd0,  4'b0000, 6'd63);
        applyStimulus(6'd0, 3'd0, 1'b0);     checkOutput("idle6",    6'd0,  4'b0000, 6'd63);
        applyStimulus(6'd1, 3'd0, 1'b0);     checkOutput("ovf1",     6'd1,  4'b0000, 6'd63);

        // Asynchronous reset mid-operation, away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst", 6'd0, 4'b0000, 6'd0);

        // A coin already present at reset release counts on the first edge.
        @(negedge clk);
        money = 6'd5;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst", 6'd0, 4'b0000, 6'd5);
        applyStimulus(6'd5, 3'd0, 1'b1);     checkOutput("cancel5",  6'd5, 4'b0000, 6'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
